hack_ctrl_unit: RTL and testbench

//  Multi-cycle control unit for the 16-bit Hack-style CPU. It fetches instructions

---
 rtl/hack_ctrl_unit.sv | 104 ++++++++++
 tb/tb_hack_ctrl_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hack_ctrl_unit.sv
// rtl/hack_ctrl_unit.sv - multi-cycle fetch/decode/execute/writeback control for a 16-bit Hack CPU
module hack_ctrl_unit #(
  parameter int               ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [5:0]        alu_ctl,
  input  logic [15:0]       alu_o,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;

  state_t            state, state_nxt;
  logic [15:0]       ir, a_reg, d_reg, res;
  logic              zr_q, ng_q;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic [5:0]        ctl_q;
  logic              take;

  assign pc_inc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign take   = (ir[2] & ng_q) | (ir[1] & zr_q) | (ir[0] & ~ng_q & ~zr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = ir[15] ? S_EXEC : S_FETCH;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Gating with rst_n keeps both strobes low for the whole reset window.
  always_comb begin
    instr_req = rst_n && (state == S_FETCH);
    mem_we    = rst_n && (state == S_WB) && ir[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      ir    <= '0;
      a_reg <= '0;
      d_reg <= '0;
      res   <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
      ctl_q <= '0;
    end else begin
      case (state)
        S_FETCH: if (instr_valid) ir <= instr;
        S_DECODE: begin
          if (ir[15]) begin
            ctl_q <= ir[11:6];
          end else begin
            a_reg <= ir;
            pc    <= pc_inc;
          end
        end
        S_EXEC: begin
          res  <= alu_o;
          zr_q <= alu_zr;
          ng_q <= alu_ng;
        end
        S_WB: begin
          // Jump target and memory address both use A as it was before this write.
          if (ir[4]) d_reg <= res;
          if (ir[5]) a_reg <= res;
          pc <= take ? a_reg[ADDR_W-1:0] : pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign instr_addr = pc;
  assign pc_out     = pc;
  assign alu_x      = d_reg;
  assign alu_y      = ir[12] ? mem_rdata : a_reg;
  assign alu_ctl    = ctl_q;
  assign mem_addr   = a_reg[ADDR_W-1:0];
  assign mem_wdata  = res;

endmodule

// File: tb/tb_hack_ctrl_unit.sv
// tb/tb_hack_ctrl_unit.sv - table-driven scoreboard bench for hack_ctrl_unit
module tb_hack_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] alu_x, alu_y, alu_o;
  logic [5:0]  alu_ctl;
  logic        alu_zr, alu_ng;
  logic [14:0] mem_addr;
  logic [15:0] mem_rdata, mem_wdata;
  logic        mem_we;
  logic [14:0] pc_out;

  logic [15:0] mem [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] word;
    int          dly;
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    int          we;
    logic [14:0] waddr;
    logic [15:0] wdata;
    logic        is_c;
    logic [5:0]  ctl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  hack_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr(instr), .alu_x(alu_x), .alu_y(alu_y),
    .alu_ctl(alu_ctl), .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [15:0] x, y, o;
    x = alu_ctl[5] ? 16'h0000 : alu_x;
    x = alu_ctl[4] ? ~x : x;
    y = alu_ctl[3] ? 16'h0000 : alu_y;
    y = alu_ctl[2] ? ~y : y;
    o = alu_ctl[1] ? (x + y) : (x & y);
    o = alu_ctl[0] ? ~o : o;
    alu_o  = o;
    alu_zr = (o == 16'h0000);
    alu_ng = o[15];
  end

  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] w, input int dly, input logic [14:0] pc,
                     input logic [15:0] a, input logic [15:0] d, input int we,
                     input logic [14:0] waddr, input logic [15:0] wdata,
                     input logic is_c, input logic [5:0] ctl);
    vec_t v;
    v.word = w; v.dly = dly; v.pc = pc; v.a = a; v.d = d; v.we = we;
    v.waddr = waddr; v.wdata = wdata; v.is_c = is_c; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, we_cnt;
    logic [14:0] waddr;
    logic [15:0] wdata;
    vec_t e;
    we_cnt = 0; waddr = '0; wdata = '0;
    for (int k = 0; k < v.dly; k++) begin
      instr_valid = 1'b0;
      chk($sformatf("req_hold[%0d]", idx), instr_req, 1);
      @(negedge clk);
    end
    chk($sformatf("req[%0d]", idx), instr_req, 1);
    instr = v.word;
    instr_valid = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    cyc = 1;
    instr = 16'hFFFF;
    while (!instr_req && cyc < 20) begin
      if (mem_we) begin
        we_cnt++;
        waddr = mem_addr;
        wdata = mem_wdata;
      end
      @(negedge clk);
      instr_valid = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    chk($sformatf("cycles[%0d]", idx), cyc, e.is_c ? 4 : 2);
    chk($sformatf("pc[%0d]", idx), pc_out, e.pc);
    chk($sformatf("instr_addr[%0d]", idx), instr_addr, e.pc);
    chk($sformatf("a[%0d]", idx), mem_addr, e.a[14:0]);
    chk($sformatf("d[%0d]", idx), alu_x, e.d);
    chk($sformatf("we_cnt[%0d]", idx), we_cnt, e.we);
    if (e.we != 0) begin
      chk($sformatf("waddr[%0d]", idx), waddr, e.waddr);
      chk($sformatf("wdata[%0d]", idx), wdata, e.wdata);
    end
    if (e.is_c) chk($sformatf("ctl[%0d]", idx), alu_ctl, e.ctl);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    //   word     dly pc       A        D        we addr  wdata    C  ctl
    add(16'h0005, 0, 15'd1,    16'd5,   16'd0,   0, 0,    16'd0,   0, 6'b000000);
    add(16'hEC10, 0, 15'd2,    16'd5,   16'd5,   0, 0,    16'd0,   1, 6'b110000);
    add(16'h000A, 0, 15'd3,    16'd10,  16'd5,   0, 0,    16'd0,   0, 6'b000000);
    add(16'hE301, 0, 15'd10,   16'd10,  16'd5,   0, 0,    16'd0,   1, 6'b001100);
    add(16'hEA90, 0, 15'd11,   16'd10,  16'd0,   0, 0,    16'd0,   1, 6'b101010);
    add(16'hE301, 1, 15'd12,   16'd10,  16'd0,   0, 0,    16'd0,   1, 6'b001100);
    add(16'hEE90, 0, 15'd13,   16'd10,  16'hFFFF,0, 0,    16'd0,   1, 6'b111010);
    add(16'hE301, 0, 15'd14,   16'd10,  16'hFFFF,0, 0,    16'd0,   1, 6'b001100);
    add(16'h0007, 0, 15'd15,   16'd7,   16'hFFFF,0, 0,    16'd0,   0, 6'b000000);
    add(16'hEC10, 0, 15'd16,   16'd7,   16'd7,   0, 0,    16'd0,   1, 6'b110000);
    add(16'h0003, 2, 15'd17,   16'd3,   16'd7,   0, 0,    16'd0,   0, 6'b000000);
    add(16'hE7C8, 0, 15'd18,   16'd3,   16'd7,   1, 3,    16'd8,   1, 6'b011111);
    add(16'hFC10, 0, 15'd19,   16'd3,   16'd8,   0, 0,    16'd0,   1, 6'b110000);
    add(16'hE7EF, 0, 15'd3,    16'd9,   16'd8,   1, 3,    16'd9,   1, 6'b011111);
    add(16'h8C10, 0, 15'd4,    16'd9,   16'd9,   0, 0,    16'd0,   1, 6'b110000);
    add(16'h7FFF, 0, 15'd5,    16'h7FFF,16'd9,   0, 0,    16'd0,   0, 6'b000000);
    add(16'hEA87, 0, 15'h7FFF, 16'h7FFF,16'd9,   0, 0,    16'd0,   1, 6'b101010);
    add(16'h0001, 3, 15'd0,    16'd1,   16'd9,   0, 0,    16'd0,   0, 6'b000000);

    repeat (2) @(negedge clk);
    chk("rst_req", instr_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_ctl", alu_ctl, 0);
    chk("rst_d", alu_x, 0);
    chk("rst_a", mem_addr, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", instr_req, 1);

    // Reset asserted while a memory write is in progress.
    @(negedge clk);
    instr = 16'hEC08;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wb_reached", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("wb_rst_we", mem_we, 0);
    chk("wb_rst_req", instr_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("wb_rst_pc", pc_out, 0);
    chk("wb_rst_req_hi", instr_req, 1);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
